// File: rtl/mc14433_digit_scan_pkg.sv
// mc14433_pkg
// Shared types and constants for the MC14433 digit-scan output stage.
// Contents:
//   DS_SLOT1..DS_SLOT4 / DS_NONE : one-hot digit strobe patterns
//   state_t                      : top-level scan state {IDLE, SCAN}
//   phase_t                      : slot phase {ON, GAP}
//   NIB_*                        : bit positions of the DS1 status nibble
//   reading_t                    : one captured conversion result
package mc14433_pkg;

  localparam logic [3:0] DS_NONE  = 4'b0000;
  localparam logic [3:0] DS_SLOT1 = 4'b0001;
  localparam logic [3:0] DS_SLOT2 = 4'b0010;
  localparam logic [3:0] DS_SLOT3 = 4'b0100;
  localparam logic [3:0] DS_SLOT4 = 4'b1000;

  typedef enum logic {IDLE, SCAN} state_t;
  typedef enum logic {ON, GAP} phase_t;

  // DS1 slot nibble layout: {~msd, pol, ur, ovr}
  localparam int NIB_MSD_N = 3;
  localparam int NIB_POL   = 2;
  localparam int NIB_UR    = 1;
  localparam int NIB_OVR   = 0;

  typedef struct packed {
    logic       msd;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    logic       pol;
    logic       ovr;
  } reading_t;

  // Slot index 0..3 maps to DS[1]..DS[4]
  function automatic logic [3:0] ds_onehot(input logic [1:0] slot);
    case (slot)
      2'd0:    return DS_SLOT1;
      2'd1:    return DS_SLOT2;
      2'd2:    return DS_SLOT3;
      default: return DS_SLOT4;
    endcase
  endfunction

endpackage

// File: rtl/mc14433_digit_scan_scan_timer.sv
// scan_timer
// Phase-length down-counter for the digit scan. Loading W-bit value N
// makes tc high N+1 cycles later, so loading LEN-1 yields a phase of
// LEN cycles when the owner reloads on tc.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset (count cleared)
//   load     : load load_val this edge
//   load_val : next phase length minus one
//   tc       : terminal count (count is zero)
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Counter parks at zero when not reloaded; the owner ignores tc while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mc14433_digit_scan.sv
// mc14433_digit_scan
// MC14433 output stage: captures each finished conversion into a pending
// buffer, transfers it into the display latch at the start of a DS1 slot,
// and scans the latched value out as multiplexed BCD with one-hot strobes.
// Optional macro: MC14433_UR_DETECT_EN enables the under-range (< 0180)
// flag in the DS1 status nibble; otherwise that bit is tied to 0.
// Ports:
//   CP                  : clock, rising edge
//   R                   : synchronous active-low reset
//   conv_done           : one-cycle strobe, count inputs valid with it
//   msd, bcd_h/t/u      : half digit and hundreds/tens/units BCD
//   pol, ovr            : polarity (1 = positive), over-range
//   Q                   : multiplexed BCD / status nibble
//   DS                  : one-hot digit strobes, DS[1] = MSD slot
//   EOC                 : pulse when a new value enters the display latch
//   OR_B                : active-low over-range from the display latch
module mc14433_digit_scan
  import mc14433_pkg::*;
#(
  parameter int DIG_CYCLES = 18,
  parameter int GAP_CYCLES = 2
) (
  input  logic       CP,
  input  logic       R,
  input  logic       conv_done,
  input  logic       msd,
  input  logic [3:0] bcd_h,
  input  logic [3:0] bcd_t,
  input  logic [3:0] bcd_u,
  input  logic       pol,
  input  logic       ovr,
  output logic [3:0] Q,
  output logic [3:0] DS,
  output logic       EOC,
  output logic       OR_B
);

  state_t     state;
  phase_t     phase;
  logic [1:0] slot;
  logic [1:0] next_slot;
  reading_t   incoming;
  reading_t   pend;
  logic       pend_vld;
  reading_t   disp;
  logic       tc;
  logic       tload;
  logic [7:0] tval;

  assign incoming  = '{msd: msd, h: bcd_h, t: bcd_t, u: bcd_u, pol: pol, ovr: ovr};
  assign next_slot = slot + 2'd1;

  // Reload the timer whenever a phase begins: on the IDLE exit and on every
  // terminal count while scanning. The length is that of the phase entered.
  assign tload = ((state == IDLE) && conv_done) || ((state == SCAN) && tc);
  assign tval  = ((state == SCAN) && (phase == ON)) ? 8'(GAP_CYCLES - 1)
                                                    : 8'(DIG_CYCLES - 1);

  scan_timer #(.W(8)) u_timer (
    .clk      (CP),
    .rst_n    (R),
    .load     (tload),
    .load_val (tval),
    .tc       (tc)
  );

  function automatic logic [3:0] status_nib(input reading_t r);
    logic [3:0] n;
    logic       ur;
`ifdef MC14433_UR_DETECT_EN
    ur = !r.msd && !r.ovr && ((r.h == 4'd0) || ((r.h == 4'd1) && (r.t < 4'd8)));
`else
    ur = 1'b0;
`endif
    n            = '0;
    n[NIB_MSD_N] = ~r.msd;
    n[NIB_POL]   = r.pol;
    n[NIB_UR]    = ur;
    n[NIB_OVR]   = r.ovr;
    return n;
  endfunction

  function automatic logic [3:0] slot_digit(input logic [1:0] s, input reading_t r);
    case (s)
      2'd1:    return r.h;
      2'd2:    return r.t;
      2'd3:    return r.u;
      default: return status_nib(r);
    endcase
  endfunction

  // Scan FSM with registered outputs. The capture into the pending buffer is
  // written first so a transfer in the same cycle still reads the old pending
  // value while the new one lands in the buffer with the flag kept set.
  always_ff @(posedge CP) begin
    if (!R) begin
      state    <= IDLE;
      phase    <= ON;
      slot     <= 2'd0;
      pend     <= '0;
      pend_vld <= 1'b0;
      disp     <= '0;
      Q        <= 4'd0;
      DS       <= DS_NONE;
      EOC      <= 1'b0;
      OR_B     <= 1'b1;
    end else begin
      EOC <= 1'b0;
      if (conv_done) begin
        pend     <= incoming;
        pend_vld <= 1'b1;
      end
      case (state)
        IDLE: begin
          // First result goes straight to the display and starts the frame.
          if (conv_done) begin
            state    <= SCAN;
            phase    <= ON;
            slot     <= 2'd0;
            disp     <= incoming;
            pend_vld <= 1'b0;
            EOC      <= 1'b1;
            OR_B     <= ~incoming.ovr;
            DS       <= DS_SLOT1;
            Q        <= status_nib(incoming);
          end
        end
        SCAN: begin
          if (tc) begin
            if (phase == ON) begin
              phase <= GAP;
              DS    <= DS_NONE;
            end else begin
              phase <= ON;
              slot  <= next_slot;
              DS    <= ds_onehot(next_slot);
              if (next_slot == 2'd0) begin
                if (pend_vld) begin
                  disp     <= pend;
                  pend_vld <= conv_done;
                  EOC      <= 1'b1;
                  OR_B     <= ~pend.ovr;
                  Q        <= status_nib(pend);
                end else begin
                  Q <= status_nib(disp);
                end
              end else begin
                Q <= slot_digit(next_slot, disp);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc14433_digit_scan.sv
// tb_mc14433_digit_scan
// Self-checking bench for mc14433_digit_scan. A reference model tracks the
// position inside the 80-cycle frame as a plain integer and derives the
// expected strobes, nibble, EOC and OR_B from it every cycle.
module tb_mc14433_digit_scan;

  localparam int DIG   = 18;
  localparam int GAP   = 2;
  localparam int SLOT  = DIG + GAP;
  localparam int FRAME = 4 * SLOT;

  logic       CP = 1'b0;
  logic       R = 1'b0;
  logic       conv_done = 1'b0;
  logic       msd = 1'b0;
  logic [3:0] bcd_h = 4'd0;
  logic [3:0] bcd_t = 4'd0;
  logic [3:0] bcd_u = 4'd0;
  logic       pol = 1'b0;
  logic       ovr = 1'b0;
  logic [3:0] Q;
  logic [3:0] DS;
  logic       EOC;
  logic       OR_B;

  mc14433_digit_scan #(.DIG_CYCLES(DIG), .GAP_CYCLES(GAP)) dut (
    .CP        (CP),
    .R         (R),
    .conv_done (conv_done),
    .msd       (msd),
    .bcd_h     (bcd_h),
    .bcd_t     (bcd_t),
    .bcd_u     (bcd_u),
    .pol       (pol),
    .ovr       (ovr),
    .Q         (Q),
    .DS        (DS),
    .EOC       (EOC),
    .OR_B      (OR_B)
  );

  always #5 CP = ~CP;

  typedef struct {
    int msd;
    int h;
    int t;
    int u;
    bit pol;
    bit ovr;
  } rd_t;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  bit         m_scan = 1'b0;
  int         m_pos = 0;
  bit         m_pvld = 1'b0;
  rd_t        m_pend;
  rd_t        m_lat;
  logic [3:0] m_q = 4'd0;
  logic [3:0] m_ds = 4'd0;
  bit         m_eoc = 1'b0;
  bit         m_orb = 1'b1;

  function automatic rd_t mk(int a, int b, int c, int d, bit p, bit o);
    rd_t r;
    r.msd = a; r.h = b; r.t = c; r.u = d; r.pol = p; r.ovr = o;
    return r;
  endfunction

  function automatic rd_t rand_rd();
    return mk(int'($urandom_range(1)), int'($urandom_range(9)), int'($urandom_range(9)),
              int'($urandom_range(9)), 1'($urandom_range(1)), 1'($urandom_range(1)));
  endfunction

  // Status nibble from the reading's numeric value
  function automatic logic [3:0] nib(rd_t r);
    bit ur;
    ur = 1'b0;
`ifdef MC14433_UR_DETECT_EN
    begin
      int val;
      val = r.msd * 1000 + r.h * 100 + r.t * 10 + r.u;
      ur  = (val < 180) && !r.ovr;
    end
`endif
    return {r.msd == 0, r.pol, ur, r.ovr};
  endfunction

  function automatic rd_t cur_in();
    return mk(int'(msd), int'(bcd_h), int'(bcd_t), int'(bcd_u), pol, ovr);
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_q, m_ds, m_eoc, m_orb};
  endfunction

  task automatic model_edge();
    rd_t v;
    int  s;
    int  w;
    v = cur_in();
    if (!R) begin
      m_scan = 0; m_pvld = 0; m_lat = mk(0, 0, 0, 0, 0, 0);
      m_eoc = 0; m_q = 4'd0; m_ds = 4'd0; m_orb = 1;
      return;
    end
    m_eoc = 0;
    if (!m_scan) begin
      if (conv_done) begin
        m_scan = 1; m_pos = 0; m_lat = v; m_eoc = 1;
        m_orb = !v.ovr; m_q = nib(v); m_ds = 4'b0001;
      end
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      s = m_pos / SLOT;
      w = m_pos % SLOT;
      if (w == 0) begin
        if (s == 0 && m_pvld) begin
          m_lat = m_pend; m_pvld = 0; m_eoc = 1; m_orb = !m_pend.ovr;
        end
        case (s)
          0: m_q = nib(m_lat);
          1: m_q = 4'(m_lat.h);
          2: m_q = 4'(m_lat.t);
          default: m_q = 4'(m_lat.u);
        endcase
      end
      m_ds = (w < DIG) ? (4'b0001 << s) : 4'b0000;
      if (conv_done) begin
        m_pend = v; m_pvld = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CP);
    model_edge();
    @(negedge CP);
    conv_done = 1'b0;
    cyc++;
  endtask

  task automatic drive(rd_t v);
    msd = 1'(v.msd); bcd_h = 4'(v.h); bcd_t = 4'(v.t); bcd_u = 4'(v.u);
    pol = v.pol; ovr = v.ovr; conv_done = 1'b1;
  endtask

  // Step and compare until the model reaches frame position tgt (bounded)
  task automatic advance(int tgt, string nm);
    for (int i = 0; i <= FRAME + 1; i++) begin
      if (m_scan && m_pos == tgt) return;
      tick();
      checks++;
      if ({Q, DS, EOC, OR_B} !== exp_vec()) begin
        errs++;
        $display("[TB] FAIL %s cyc=%0d got QDSEO=%b want=%b", nm, cyc, {Q, DS, EOC, OR_B}, exp_vec());
      end
    end
    errs++;
    $display("[TB] FAIL %s_timeout cyc=%0d got pos=%0d want pos=%0d", nm, cyc, m_pos, tgt);
  endtask

  task automatic test_reset();
    R = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if ({Q, DS, EOC, OR_B} !== 10'b0000_0000_0_1) begin
        errs++;
        $display("[TB] FAIL reset_values got=%b want=%b", {Q, DS, EOC, OR_B}, 10'b0000_0000_0_1);
      end
    end
    R = 1'b1;
    repeat (10) begin
      tick();
      checks++;
      if ({Q, DS, EOC, OR_B} !== exp_vec()) begin
        errs++;
        $display("[TB] FAIL idle_hold got=%b want=%b", {Q, DS, EOC, OR_B}, exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    int eocs;
    drive(mk(1, 9, 8, 7, 1, 0));
    tick();
    checks++;
    // 1987, positive, in range: {~1, 1, 0, 0}
    if ({EOC, DS, Q, OR_B} !== {1'b1, 4'b0001, 4'b0100, 1'b1}) begin
      errs++;
      $display("[TB] FAIL first_slot got EOC/DS/Q/ORB=%b want=%b", {EOC, DS, Q, OR_B},
               {1'b1, 4'b0001, 4'b0100, 1'b1});
    end
    eocs = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (EOC === 1'b1) eocs++;
      checks++;
      if ({Q, DS, EOC, OR_B} !== exp_vec()) begin
        errs++;
        $display("[TB] FAIL basic_scan cyc=%0d got=%b want=%b", cyc, {Q, DS, EOC, OR_B}, exp_vec());
      end
    end
    checks++;
    if (eocs != 0) begin
      errs++;
      $display("[TB] FAIL no_new_data_eoc got=%0d want=0", eocs);
    end
  endtask

  task automatic test_double_capture();
    int eocs;
    advance(30, "dbl_pre");
    drive(mk(0, 1, 2, 3, 1, 0));
    advance(45, "dbl_mid");
    drive(mk(0, 4, 5, 6, 0, 0));
    eocs = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      if (EOC === 1'b1) eocs++;
      checks++;
      if ({Q, DS, EOC, OR_B} !== exp_vec()) begin
        errs++;
        $display("[TB] FAIL double cyc=%0d got=%b want=%b", cyc, {Q, DS, EOC, OR_B}, exp_vec());
      end
      if (m_pos == SLOT) begin
        checks++;
        if (Q !== 4'd4) begin
          errs++;
          $display("[TB] FAIL double_latest got Q=%0d want 4", Q);
        end
      end
    end
    checks++;
    if (eocs != 1) begin
      errs++;
      $display("[TB] FAIL double_eoc_count got=%0d want=1", eocs);
    end
  endtask

  task automatic test_back_to_back();
    advance(50, "b2b_pre");
    drive(mk(1, 2, 3, 4, 1, 0));
    advance(FRAME - 1, "b2b_wait");
    drive(mk(0, 7, 6, 5, 0, 0));
    tick();
    checks++;
    if ({EOC, Q} !== {1'b1, nib(mk(1, 2, 3, 4, 1, 0))} || {Q, DS, EOC, OR_B} !== exp_vec()) begin
      errs++;
      $display("[TB] FAIL b2b_old got=%b want=%b", {Q, DS, EOC, OR_B}, exp_vec());
    end
    advance(FRAME - 1, "b2b_frame");
    tick();
    checks++;
    if ({EOC, Q} !== {1'b1, nib(mk(0, 7, 6, 5, 0, 0))} || {Q, DS, EOC, OR_B} !== exp_vec()) begin
      errs++;
      $display("[TB] FAIL b2b_new got=%b want=%b", {Q, DS, EOC, OR_B}, exp_vec());
    end
  endtask

  task automatic test_overrange();
    rd_t vals[3];
    vals[0] = mk(1, 9, 9, 9, 1, 1);
    vals[1] = mk(0, 1, 5, 0, 1, 0);
    vals[2] = mk(0, 1, 8, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      advance(10, "ovr_pre");
      drive(vals[k]);
      advance(0, "ovr_wait");
      checks++;
      if ({Q, DS, EOC, OR_B} !== exp_vec()) begin
        errs++;
        $display("[TB] FAIL ovr_ds1 k=%0d got=%b want=%b", k, {Q, DS, EOC, OR_B}, exp_vec());
      end
      if (k == 0) begin
        checks++;
        if ({OR_B, Q[0]} !== 2'b01) begin
          errs++;
          $display("[TB] FAIL ovr_flag got ORB,Q0=%b want 01", {OR_B, Q[0]});
        end
      end else begin
        checks++;
`ifdef MC14433_UR_DETECT_EN
        if (Q[1] !== (k == 1)) begin
`else
        if (Q[1] !== 1'b0) begin
`endif
          errs++;
          $display("[TB] FAIL ur_flag k=%0d got Q1=%b", k, Q[1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30 * FRAME; i++) begin
      if ($urandom_range(39) == 0) drive(rand_rd());
      tick();
      checks++;
      if ({Q, DS, EOC, OR_B} !== exp_vec()) begin
        errs++;
        $display("[TB] FAIL random cyc=%0d got=%b want=%b", cyc, {Q, DS, EOC, OR_B}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    advance(2 * SLOT + 5, "rst_pre");
    R = 1'b0;
    tick();
    checks++;
    if ({Q, DS, EOC, OR_B} !== 10'b0000_0000_0_1) begin
      errs++;
      $display("[TB] FAIL reset_mid got=%b want=%b", {Q, DS, EOC, OR_B}, 10'b0000_0000_0_1);
    end
    R = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (DS !== 4'b0000 || {Q, DS, EOC, OR_B} !== exp_vec()) begin
        errs++;
        $display("[TB] FAIL post_reset_idle cyc=%0d got=%b want=%b", cyc, {Q, DS, EOC, OR_B}, exp_vec());
      end
    end
    drive(mk(0, 0, 4, 2, 0, 0));
    tick();
    checks++;
    if ({EOC, DS} !== 5'b1_0001 || {Q, DS, EOC, OR_B} !== exp_vec()) begin
      errs++;
      $display("[TB] FAIL restart got=%b want=%b", {Q, DS, EOC, OR_B}, exp_vec());
    end
    advance(FRAME - 1, "restart_scan");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_double_capture();
    test_back_to_back();
    test_overrange();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
